// File: rtl/multicycle_adder.sv
// multicycle_adder: digit-serial adder producing (a + b + cin) DIGIT bits per cycle
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only when idle)
//   a, b, cin            addends and carry-in, captured on accept
//   out_valid/out_ready  result handshake (out_valid high only while holding a result)
//   sum, cout, ovf       result, carry out of the MSB, two's-complement overflow
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] ar, br;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             last;
  assign dsum = {1'b0, ar[DIGIT-1:0]} + {1'b0, br[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
  assign last = cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      ar        <= '0;
      br        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ar       <= a;
          br       <= b;
          c        <= cin;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          // each new digit enters at the MSB end so the last digit lands on top
          sum <= (sum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
          c   <= dsum[DIGIT];
          ar  <= ar >> DIGIT;
          br  <= br >> DIGIT;
          cnt <= cnt + CW'(1);
          if (last) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            cout      <= dsum[DIGIT];
            // carry into the MSB recovered as a ^ b ^ sum at that bit
            ovf       <= ar[DIGIT-1] ^ br[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: table-driven scoreboard bench for three adder configurations
module tb_multicycle_adder;
  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] s;
    logic       co, ov;
    int         hold;
  } vec_t;
  typedef struct {
    logic [7:0] s;
    logic       co, ov;
  } exp_t;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      iv = '0, ordy = '0, tc = '0;
  logic [2:0][7:0] ta = '0, tb = '0;
  logic [2:0]      rdy, ov, co, of;
  logic [2:0][7:0] s;
  exp_t            sb[$];
  int              lat[3] = '{4, 1, 1};
  int              errs = 0, nchk = 0;
  always #5 clk = ~clk;
  assign s[1][7:1] = '0;
  multicycle_adder #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .a(ta[0]), .b(tb[0]), .cin(tc[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(s[0]), .cout(co[0]), .ovf(of[0]));
  multicycle_adder #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .a(ta[1][0]), .b(tb[1][0]), .cin(tc[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s[1][0]), .cout(co[1]), .ovf(of[1]));
  multicycle_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
    .a(ta[2]), .b(tb[2]), .cin(tc[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(s[2]), .cout(co[2]), .ovf(of[2]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // entered just after a negedge; returns just after a negedge with the DUT idle
  task automatic op(input int d, input logic [7:0] ea, input logic [7:0] eb, input logic ec,
                    input logic [7:0] es, input logic eco, input logic eov,
                    input int hold, input string nm);
    int   n;
    exp_t r;
    chk({nm, "_in_ready"}, 32'(rdy[d]), 1);
    ta[d] = ea; tb[d] = eb; tc[d] = ec; iv[d] = 1'b1;
    sb.push_back('{es, eco, eov});
    @(posedge clk);
    @(negedge clk);
    ta[d] = ~ea; tb[d] = ~eb; tc[d] = ~ec; ordy[d] = 1'b1;
    n = 0;
    while (!ov[d] && n < lat[d] + 4) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    ordy[d] = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'(lat[d]));
    r = sb.pop_front();
    chk({nm, "_sum"}, 32'(s[d]), 32'(r.s));
    chk({nm, "_cout"}, 32'(co[d]), 32'(r.co));
    chk({nm, "_ovf"}, 32'(of[d]), 32'(r.ov));
    for (int i = 0; i < hold; i++) begin
      ta[d] = ta[d] + 8'h5b; tb[d] = ~tb[d]; tc[d] = ~tc[d];
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_hold"}, {s[d], co[d], of[d], ov[d], rdy[d]}, {r.s, r.co, r.ov, 1'b1, 1'b0});
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[d] = 1'b0;
    iv[d] = 1'b0;
    chk({nm, "_release"}, {ov[d], rdy[d]}, 2'b01);
    chk({nm, "_idle_keep"}, {s[d], co[d], of[d]}, {r.s, r.co, r.ov});
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t       tbl[8];
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic       rc, bad;
    tbl = '{
      '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0},
      '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 3},
      '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0},
      '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 2},
      '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, 0}
    };
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("reset_hs%0d", d), {ov[d], rdy[d]}, 2'b01);
    chk("reset_out", {s[0], co[0], of[0]}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      op(0, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].hold,
         $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      m = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      op(0, ra, rb, rc, m[7:0], m[8], (ra[7] == rb[7]) && (m[7] != ra[7]),
         int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end
    ta[0] = 8'h55; tb[0] = 8'h0F; tc[0] = 1'b1; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_hs", {ov[0], rdy[0]}, 2'b01);
    chk("midrun_rst_out", {s[0], co[0], of[0]}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) bad = 1'b1;
    end
    chk("midrun_no_ovalid", 32'(bad), 0);
    op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, "post_rst");
    for (int i = 0; i < 8; i++) begin
      ra = 8'(i[2]); rb = 8'(i[1]); rc = i[0];
      m = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      op(1, ra, rb, rc, {7'b0, m[0]}, m[1], rc ^ m[1], i % 2, $sformatf("fa%0d", i));
    end
    op(2, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1, "n1_aa55");
    op(2, 8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1, 0, "n1_7f7f");
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be at least 1.
REQ-002 Parameter DIGIT, default 2: bits added per cycle; SHALL divide WIDTH exactly. N = WIDTH/DIGIT is the number of add cycles.
REQ-003 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 IN_VALID  input  1  operand set presented.
REQ-006 IN_READY  output  1  block can accept an operand set.
REQ-007 A  input  WIDTH  addend.
REQ-008 B  input  WIDTH  addend.
REQ-009 CIN  input  1  carry-in.
REQ-010 OUT_VALID  output  1  result available.
REQ-011 OUT_READY  input  1  consumer takes the result.
REQ-012 SUM  output  WIDTH  (A + B + CIN) mod 2^WIDTH.
REQ-013 COUT  output  1  carry out of bit WIDTH-1.
REQ-014 OVF  output  1  two's-complement overflow: carry into bit WIDTH-1 XOR COUT.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and HOLD. IN_READY SHALL be 1 only in IDLE, and OUT_VALID SHALL be 1 only in HOLD.
REQ-016 IDLE: on IN_VALID=1 at a clock edge, the block SHALL register A, B and CIN, clear the digit counter, and enter RUN. With IN_VALID=0 it SHALL stay in IDLE.
REQ-017 RUN: each cycle SHALL add the lowest DIGIT bits of the A and B registers plus the carry register.
- The DIGIT-bit sum SHALL be shifted into SUM from the MSB side.
- The carry register SHALL be updated.
- The A and B registers SHALL shift right by DIGIT.
- The counter SHALL increment.
REQ-018 The counter SHALL be ceil(log2(N+1)) bits wide. After the Nth RUN cycle the block SHALL enter HOLD, with COUT equal to the final carry and OVF computed as in REQ-014.
REQ-019 Latency: for an accept at edge k, OUT_VALID SHALL rise after edge k+N. For N=1, HOLD SHALL follow RUN after a single cycle.
REQ-020 HOLD: SUM, COUT and OVF SHALL stay stable while OUT_VALID=1 and OUT_READY=0, for any number of cycles.
REQ-021 HOLD with OUT_READY=1 SHALL move to IDLE on the next edge. An operand set SHALL NOT be accepted in that same cycle, because IN_READY=0 in HOLD.
REQ-022 Changes on A, B, CIN and IN_VALID during RUN or HOLD SHALL have no effect.
REQ-023 OUT_READY SHALL be ignored outside HOLD.
REQ-024 SUM, COUT and OVF SHALL keep the last result in IDLE until the next accept. They are undefined during RUN and are valid only while OUT_VALID=1.
REQ-025 No internal path SHALL be combinational from an input to an output, with one exception: none exist, because IN_READY and OUT_VALID are decoded from state only.

Reset
REQ-026 RST_N=0 SHALL set, immediately and regardless of CLK, the state to IDLE and IN_READY=1. It SHALL also set OUT_VALID=0, SUM=0, COUT=0 and OVF=0, and clear the counter, carry and operand registers.
REQ-027 Reset asserted during RUN or HOLD SHALL discard the operation in progress. No OUT_VALID pulse SHALL follow.
REQ-028 After RST_N rises, the first edge with IN_VALID=1 SHALL be accepted.

Verification (WIDTH=8, DIGIT=2, N=4 unless noted)
REQ-029 A=0x00, B=0x00, CIN=0 accepted at edge k -> OUT_VALID at k+4 with SUM=0x00, COUT=0, OVF=0.
REQ-030 A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0. Also A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1, OVF=0.
REQ-031 A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0, OVF=1. Also A=0x80, B=0x80, CIN=0 -> SUM=0x00, COUT=1, OVF=1.
REQ-032 Backpressure: hold OUT_READY=0 for 3 cycles and toggle A and B meanwhile -> outputs unchanged and IN_READY=0. Then raise OUT_READY -> IDLE next cycle and IN_READY=1.
REQ-033 Assert RST_N=0 after 2 RUN cycles -> all outputs 0 and IN_READY=1 immediately. Release reset and add 0x12+0x34 -> SUM=0x46 after 4 cycles.
REQ-034 WIDTH=1, DIGIT=1: all 8 combinations of A, B and CIN -> SUM and COUT match the full-adder truth table, with OUT_VALID one cycle after each accept. Then WIDTH=8, DIGIT=8 (N=1): 0xAA+0x55+1 -> SUM=0x00, COUT=1.
